cfs_md_aligner_core: RTL and testbench
======================================

Name: cfs_md_aligner_core

Overview:
- Sits between the MD RX port and the MD TX port and owns both handshakes.
- Accepts MD transfers with arbitrary legal size/offset and packs the valid bytes into an internal byte buffer.
- Emits MD transfers whose size/offset are set by the register block (ctrl_size/ctrl_offset).
- Rejects illegal RX transfers with err.

Parameters:
- DATA_WIDTH, 32: MD data width in bits. Must be a power of 2 and at least 8.
- Derived localparams, not overridable:
  - BYTES = DATA_WIDTH/8.
  - BUF_BYTES = 2*BYTES.
  - OFFSET_WIDTH = max(1, clog2(BYTES)).
  - SIZE_WIDTH = clog2(BYTES)+1.
  - LVL_WIDTH = clog2(BUF_BYTES)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  MD RX valid.
- rx_data  in  DATA_WIDTH  MD RX data.
- rx_offset  in  OFFSET_WIDTH  MD RX byte offset.
- rx_size  in  SIZE_WIDTH  MD RX byte count.
- rx_ready  out  1  MD RX ready.
- rx_err  out  1  MD RX error, meaningful only when rx_valid&rx_ready.
- tx_valid  out  1  MD TX valid.
- tx_data  out  DATA_WIDTH  MD TX data.
- tx_offset  out  OFFSET_WIDTH  MD TX offset.
- tx_size  out  SIZE_WIDTH  MD TX size.
- tx_ready  in  1  MD TX ready.
- tx_err  in  1  MD TX error.
- ctrl_size  in  SIZE_WIDTH  configured TX size.
- ctrl_offset  in  OFFSET_WIDTH  configured TX offset.
- ctrl_clr  in  1  one-cycle pulse that flushes the buffer.
- buf_lvl  out  LVL_WIDTH  bytes currently held in the buffer.
- status_cnt_drop  out  8  RX transfers answered with err; saturates at 255.
- status_cnt_tx_err  out  8  TX handshakes with tx_err=1; saturates at 255.

Behaviour:
- Reset:
  - Asynchronous: all of the following clear immediately and asynchronously, including an in-flight TX word.
  - Outputs that clear to 0: rx_ready, rx_err, tx_valid, tx_data, tx_offset, tx_size, buf_lvl, both counters.
  - RX FSM returns to IDLE.
- RX FSM, states IDLE and RESP:
  - IDLE -> RESP on the edge where rx_valid=1 and either the transfer is illegal, or buf_lvl_next + rx_size <= BUF_BYTES.
  - In RESP: rx_ready = 1. It is registered, high for exactly one cycle.
  - RESP -> IDLE unconditionally.
  - Result: minimum one bubble cycle between RX transfers.
- RX legality: a transfer is illegal if rx_size==0 or rx_offset+rx_size > BYTES.
  - Evaluate with widths extended to SIZE_WIDTH+1 so the sum does not wrap.
  - rx_err = RESP & illegal, combinational from the held RX inputs.
  - Illegal transfer: no bytes stored; status_cnt_drop increments.
- RX accept (RESP & legal):
  - Lanes rx_offset..rx_offset+rx_size-1 are appended to the buffer tail in ascending lane order.
  - buf_lvl reflects the new bytes after the handshake edge.
- Buffer full: RX stays in IDLE with rx_ready=0 while space is insufficient. This is legal backpressure; the sender holds its inputs stable.
- TX load:
  - Load condition, evaluated each edge: (tx_valid==0 or tx_valid&tx_ready) and buf_lvl >= ctrl_size and ctrl config legal.
  - On load, ctrl_size bytes are popped from the head.
  - Popped bytes go to tx_data lanes ctrl_offset..ctrl_offset+ctrl_size-1; all other lanes are 0.
  - tx_size and tx_offset are captured from ctrl at load. Later ctrl changes do not affect an in-flight word.
  - tx_valid=1 from the load edge.
- Latency: RX handshake at edge N -> earliest tx_valid after edge N+1.
- Back-to-back TX with no bubble is supported.
- TX hold: tx_valid, data, offset and size stay stable until tx_ready=1.
- TX error: tx_err at handshake increments status_cnt_tx_err. The word is still consumed; there is no retry.
- Simultaneous RX accept and TX pop in one cycle: buf_lvl_next = buf_lvl + rx_size - ctrl_size.
- Space check for RX uses buf_lvl after any pop in the same cycle.
- ctrl_clr has priority over RX accept and TX pop:
  - buf_lvl becomes 0.
  - An RX handshake in the same cycle completes with rx_err=0, but its bytes are discarded.
  - An in-flight TX word is not aborted.
- Illegal ctrl config (ctrl_size==0 or ctrl_offset+ctrl_size > BYTES): no TX loads occur and RX continues until the buffer is full.
- Counters saturate at 255 and are never cleared by ctrl_clr.

Decomposition:
- Package cfs_md_aligner_pkg holds:
  - the function computing OFFSET_WIDTH/SIZE_WIDTH from DATA_WIDTH;
  - the RX FSM state enum;
  - a legality function (size, offset, bytes) -> bit, shared by the RX check and the ctrl check.
- Sub-module cfs_md_byte_buffer:
  - a byte-granular FIFO with push(n bytes, lanes), pop(n bytes), clr, and level;
  - holds shift/concatenate logic only.
- The top holds the FSM, TX register and counters.

Test Plan:
All scenarios use DATA_WIDTH=32.
1. ctrl size=4, off=0; four RX size=1 transfers 0x11@off0, 0x22@off1, 0x33@off2, 0x44@off3 -> one TX data=0x44332211, size=4, off=0.
2. ctrl size=2, off=2; RX size=4, off=0, data=0xDDCCBBAA, tx_ready=1 -> consecutive TX 0xBBAA0000 then 0xDDCC0000, size=2, off=2, no bubble.
3. RX size=3, off=2 -> rx_err=1 in the rx_ready cycle; status_cnt_drop=1; buf_lvl unchanged at 0; no TX.
4. ctrl size=1, tx_ready held 0; RX size=1 transfers until buf_lvl=8 with one word in the TX register -> next RX sees rx_ready=0 indefinitely; one tx_ready pulse -> that RX is accepted within 2 cycles.
5. Buffer at buf_lvl=3, tx_valid stalled with data 0x000000AA; pulse ctrl_clr -> buf_lvl=0 next cycle; tx_valid stays 1 with data unchanged.
6. Assert reset while tx_valid=1 is stalled -> tx_valid, rx_ready and buf_lvl drop to 0 before the next clk edge; after release, scenario 1 passes unchanged.

Source files
------------

// File: rtl/cfs_md_aligner_pkg.sv
// Shared types and helpers for the MD aligner core and its byte buffer.
package cfs_md_aligner_pkg;

   // Width of the MD offset field; never narrower than one bit.
   function automatic int calc_offset_width(input int data_width);
      int w;
      w = $clog2(data_width / 8);
      return (w < 1) ? 1 : w;
   endfunction

   // Width of the MD size field; has to hold the value BYTES itself.
   function automatic int calc_size_width(input int data_width);
      return $clog2(data_width / 8) + 1;
   endfunction

   // RX handshake FSM: wait for a transfer, then answer it for one cycle.
   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_RESP = 1'b1
   } rx_state_t;

   // A transfer is legal when it moves at least one byte and its lane window
   // fits inside the bus. Arguments are 32 bits wide, so offset+size cannot wrap.
   function automatic logic md_xfer_legal(input int unsigned size,
                                          input int unsigned offset,
                                          input int unsigned bytes);
      return (size != 0) && ((offset + size) <= bytes);
   endfunction

endpackage

// File: rtl/cfs_md_byte_buffer.sv
// Byte-granular FIFO: pops whole bytes from the head, appends a lane window
// of an MD word to the tail, and can be flushed in one cycle.
module cfs_md_byte_buffer
   import cfs_md_aligner_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   localparam int BYTES = DATA_WIDTH / 8,
   localparam int BUF_BYTES = 2 * BYTES,
   localparam int OFFSET_WIDTH = calc_offset_width(DATA_WIDTH),
   localparam int SIZE_WIDTH = calc_size_width(DATA_WIDTH),
   localparam int LVL_WIDTH = $clog2(BUF_BYTES) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_en,
   input  logic [DATA_WIDTH-1:0]   push_data,
   input  logic [OFFSET_WIDTH-1:0] push_offset,
   input  logic [SIZE_WIDTH-1:0]   push_size,
   input  logic                    pop_en,
   input  logic [SIZE_WIDTH-1:0]   pop_size,
   input  logic                    clr,
   output logic [LVL_WIDTH-1:0]    level,
   output logic [DATA_WIDTH-1:0]   head_data
);

   logic [7:0]           mem      [BUF_BYTES];
   logic [7:0]           mem_next [BUF_BYTES];
   logic [LVL_WIDTH-1:0] level_next;

   // Next contents: shift out the popped bytes, then drop the pushed lanes in
   // right behind whatever survives the pop, in ascending lane order.
   always_comb begin : next_contents
      int pop_n;
      int push_n;
      int base;
      int lane;
      pop_n  = pop_en ? int'(pop_size) : 0;
      push_n = push_en ? int'(push_size) : 0;
      base   = int'(level) - pop_n;
      lane   = 0;
      for (int i = 0; i < BUF_BYTES; i++) begin
         if ((i + pop_n) < BUF_BYTES) begin
            mem_next[i] = mem[i + pop_n];
         end else begin
            mem_next[i] = '0;
         end
         if ((i >= base) && (i < (base + push_n))) begin
            lane = int'(push_offset) + (i - base);
            if (lane < BYTES) begin
               mem_next[i] = push_data[8*lane +: 8];
            end
         end
      end
      if (clr) begin
         level_next = '0;
      end else begin
         level_next = LVL_WIDTH'(base + push_n);
      end
   end

   // Storage and fill level; a flush only resets the level, stale bytes are unreachable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level <= '0;
         for (int i = 0; i < BUF_BYTES; i++) begin
            mem[i] <= '0;
         end
      end else begin
         level <= level_next;
         for (int i = 0; i < BUF_BYTES; i++) begin
            mem[i] <= mem_next[i];
         end
      end
   end

   // The oldest BYTES bytes, presented as an MD word with byte 0 in lane 0.
   always_comb begin
      head_data = '0;
      for (int k = 0; k < BYTES; k++) begin
         head_data[8*k +: 8] = mem[k];
      end
   end

endmodule

// File: rtl/cfs_md_aligner_core.sv
// MD aligner: accepts RX transfers of any legal size/offset, packs their bytes,
// and re-emits them as TX transfers shaped by ctrl_size/ctrl_offset.
module cfs_md_aligner_core
   import cfs_md_aligner_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   localparam int BYTES = DATA_WIDTH / 8,
   localparam int BUF_BYTES = 2 * BYTES,
   localparam int OFFSET_WIDTH = calc_offset_width(DATA_WIDTH),
   localparam int SIZE_WIDTH = calc_size_width(DATA_WIDTH),
   localparam int LVL_WIDTH = $clog2(BUF_BYTES) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rx_valid,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   input  logic [OFFSET_WIDTH-1:0] rx_offset,
   input  logic [SIZE_WIDTH-1:0]   rx_size,
   output logic                    rx_ready,
   output logic                    rx_err,
   output logic                    tx_valid,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic [OFFSET_WIDTH-1:0] tx_offset,
   output logic [SIZE_WIDTH-1:0]   tx_size,
   input  logic                    tx_ready,
   input  logic                    tx_err,
   input  logic [SIZE_WIDTH-1:0]   ctrl_size,
   input  logic [OFFSET_WIDTH-1:0] ctrl_offset,
   input  logic                    ctrl_clr,
   output logic [LVL_WIDTH-1:0]    buf_lvl,
   output logic [7:0]              status_cnt_drop,
   output logic [7:0]              status_cnt_tx_err
);

   rx_state_t             rx_state;
   rx_state_t             rx_state_next;
   logic                  rx_legal;
   logic                  ctrl_legal;
   logic                  rx_space_ok;
   logic                  tx_free;
   logic                  tx_load;
   logic                  push_en;
   int                    pop_n;
   logic [DATA_WIDTH-1:0] head_data;
   logic [DATA_WIDTH-1:0] tx_data_load;

   assign rx_legal   = md_xfer_legal(32'(rx_size), 32'(rx_offset), BYTES);
   assign ctrl_legal = md_xfer_legal(32'(ctrl_size), 32'(ctrl_offset), BYTES);

   // The TX register can take a new word when empty or when its word leaves this edge.
   // A flush suppresses the pop so the flushed bytes never reach TX.
   assign tx_free = !tx_valid || tx_ready;
   assign tx_load = tx_free && ctrl_legal && !ctrl_clr &&
                    (int'(buf_lvl) >= int'(ctrl_size));
   assign pop_n   = tx_load ? int'(ctrl_size) : 0;

   // Room is judged against the level left after this edge's pop, so a
   // draining TX lets a waiting RX through on the same edge.
   assign rx_space_ok = (int'(buf_lvl) - pop_n + int'(rx_size)) <= BUF_BYTES;

   assign rx_ready = (rx_state == RX_RESP);
   assign rx_err   = rx_ready && !rx_legal;
   assign push_en  = rx_ready && rx_legal && !ctrl_clr;

   // RX FSM register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state <= RX_IDLE;
      end else begin
         rx_state <= rx_state_next;
      end
   end

   // Answer a transfer when it is illegal (no room needed) or fits; always bubble after.
   always_comb begin
      rx_state_next = rx_state;
      case (rx_state)
         RX_IDLE: begin
            if (rx_valid && (!rx_legal || rx_space_ok)) begin
               rx_state_next = RX_RESP;
            end
         end
         RX_RESP: begin
            rx_state_next = RX_IDLE;
         end
      endcase
   end

   cfs_md_byte_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buffer (
      .clk         (clk),
      .reset       (reset),
      .push_en     (push_en),
      .push_data   (rx_data),
      .push_offset (rx_offset),
      .push_size   (rx_size),
      .pop_en      (tx_load),
      .pop_size    (ctrl_size),
      .clr         (ctrl_clr),
      .level       (buf_lvl),
      .head_data   (head_data)
   );

   // Place the head bytes into lanes ctrl_offset.. of the outgoing word; other lanes stay zero.
   always_comb begin : tx_lane_placement
      int rel;
      rel          = 0;
      tx_data_load = '0;
      for (int j = 0; j < BYTES; j++) begin
         rel = j - int'(ctrl_offset);
         if ((rel >= 0) && (rel < int'(ctrl_size))) begin
            tx_data_load[8*j +: 8] = head_data[8*rel +: 8];
         end
      end
   end

   // TX word register: shape is captured at load and held until the sink takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         tx_offset <= '0;
         tx_size   <= '0;
      end else if (tx_load) begin
         tx_valid  <= 1'b1;
         tx_data   <= tx_data_load;
         tx_offset <= ctrl_offset;
         tx_size   <= ctrl_size;
      end else if (tx_valid && tx_ready) begin
         tx_valid  <= 1'b0;
      end
   end

   // Saturating status counters; a flush leaves them alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         status_cnt_drop   <= '0;
         status_cnt_tx_err <= '0;
      end else begin
         if (rx_ready && !rx_legal && (status_cnt_drop != 8'hFF)) begin
            status_cnt_drop <= status_cnt_drop + 8'd1;
         end
         if (tx_valid && tx_ready && tx_err && (status_cnt_tx_err != 8'hFF)) begin
            status_cnt_tx_err <= status_cnt_tx_err + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_cfs_md_aligner_core.sv
// Bench for cfs_md_aligner_core: byte-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cfs_md_aligner_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [31:0] rx_data = '0;
   logic [1:0]  rx_offset = '0;
   logic [2:0]  rx_size = '0;
   logic        rx_ready;
   logic        rx_err;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic [1:0]  tx_offset;
   logic [2:0]  tx_size;
   logic        tx_ready = 1'b0;
   logic        tx_err = 1'b0;
   logic [2:0]  ctrl_size = 3'd4;
   logic [1:0]  ctrl_offset = 2'd0;
   logic        ctrl_clr = 1'b0;
   logic [3:0]  buf_lvl;
   logic [7:0]  status_cnt_drop;
   logic [7:0]  status_cnt_tx_err;

   int n_checks = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Reference model state: the packed byte stream plus the TX word in flight.
   logic [7:0]  mq[$];
   bit          m_resp = 1'b0;
   bit          m_txv = 1'b0;
   logic [31:0] m_txd = '0;
   logic [1:0]  m_txo = '0;
   logic [2:0]  m_txs = '0;
   int          m_drop = 0;
   int          m_txerr = 0;

   cfs_md_aligner_core #(
      .DATA_WIDTH (32)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .rx_valid          (rx_valid),
      .rx_data           (rx_data),
      .rx_offset         (rx_offset),
      .rx_size           (rx_size),
      .rx_ready          (rx_ready),
      .rx_err            (rx_err),
      .tx_valid          (tx_valid),
      .tx_data           (tx_data),
      .tx_offset         (tx_offset),
      .tx_size           (tx_size),
      .tx_ready          (tx_ready),
      .tx_err            (tx_err),
      .ctrl_size         (ctrl_size),
      .ctrl_offset       (ctrl_offset),
      .ctrl_clr          (ctrl_clr),
      .buf_lvl           (buf_lvl),
      .status_cnt_drop   (status_cnt_drop),
      .status_cnt_tx_err (status_cnt_tx_err)
   );

   always #5 clk = ~clk;

   function automatic bit md_legal(input int size, input int off);
      return (size != 0) && ((off + size) <= 4);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step per clock edge, from the rules on the byte stream.
   initial begin
      forever begin : model_step
         int  lvl0;
         int  pop_n;
         bit  load;
         bit  rx_ok;
         bit  next_resp;
         @(posedge clk or posedge reset);
         if (reset) begin
            mq.delete();
            m_resp  = 1'b0;
            m_txv   = 1'b0;
            m_txd   = '0;
            m_txo   = '0;
            m_txs   = '0;
            m_drop  = 0;
            m_txerr = 0;
         end else begin
            lvl0  = mq.size();
            rx_ok = md_legal(int'(rx_size), int'(rx_offset));
            load  = (!m_txv || tx_ready) && md_legal(int'(ctrl_size), int'(ctrl_offset)) &&
                    !ctrl_clr && (lvl0 >= int'(ctrl_size));
            pop_n = load ? int'(ctrl_size) : 0;
            next_resp = !m_resp && rx_valid && (!rx_ok || ((lvl0 - pop_n + int'(rx_size)) <= 8));
            if (m_txv && tx_ready) begin
               if (tx_err && (m_txerr < 255)) m_txerr = m_txerr + 1;
               m_txv = 1'b0;
            end
            if (load) begin
               m_txd = '0;
               for (int k = 0; k < int'(ctrl_size); k++) begin
                  m_txd[8*(int'(ctrl_offset) + k) +: 8] = mq.pop_front();
               end
               m_txo = ctrl_offset;
               m_txs = ctrl_size;
               m_txv = 1'b1;
            end
            if (m_resp) begin
               if (!rx_ok) begin
                  if (m_drop < 255) m_drop = m_drop + 1;
               end else if (!ctrl_clr) begin
                  for (int k = 0; k < int'(rx_size); k++) begin
                     mq.push_back(rx_data[8*(int'(rx_offset) + k) +: 8]);
                  end
               end
            end
            if (ctrl_clr) mq.delete();
            m_resp = next_resp;
         end
      end
   end

   // Cycle-by-cycle comparison of the DUT against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         checkOutput("model_rx_ready", 32'(rx_ready), 32'(m_resp));
         if (m_resp) checkOutput("model_rx_err", 32'(rx_err), 32'(!md_legal(int'(rx_size), int'(rx_offset))));
         checkOutput("model_tx_valid", 32'(tx_valid), 32'(m_txv));
         if (m_txv) begin
            checkOutput("model_tx_data", tx_data, m_txd);
            checkOutput("model_tx_size", 32'(tx_size), 32'(m_txs));
            checkOutput("model_tx_offset", 32'(tx_offset), 32'(m_txo));
         end
         checkOutput("model_buf_lvl", 32'(buf_lvl), 32'(mq.size()));
         checkOutput("model_cnt_drop", 32'(status_cnt_drop), 32'(m_drop));
         checkOutput("model_cnt_tx_err", 32'(status_cnt_tx_err), 32'(m_txerr));
      end
   end

   // One RX transfer: hold inputs until answered, check rx_err in the answer cycle.
   task automatic applyStimulus(input logic [31:0] data, input int off, input int size, input logic exp_err);
      bit seen;
      seen      = 1'b0;
      rx_valid  = 1'b1;
      rx_data   = data;
      rx_offset = 2'(off);
      rx_size   = 3'(size);
      for (int i = 0; (i < 50) && !seen; i++) begin
         @(negedge clk);
         if (rx_ready) seen = 1'b1;
      end
      if (!seen) checkOutput("rx_handshake_timeout", 32'(rx_ready), 32'd1);
      else checkOutput("rx_err_at_ready", 32'(rx_err), 32'(exp_err));
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic waitTxValid(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; (i < 20) && !seen; i++) begin
         @(negedge clk);
         if (tx_valid) seen = 1'b1;
      end
      if (!seen) checkOutput(name, 32'(tx_valid), 32'd1);
   endtask

   // Four single-byte transfers packed into one full word; consumed with tx_err set.
   task automatic runPackScenario();
      ctrl_size   = 3'd4;
      ctrl_offset = 2'd0;
      tx_ready    = 1'b0;
      applyStimulus(32'hEEEEEE11, 0, 1, 1'b0);
      applyStimulus(32'hEEEE22EE, 1, 1, 1'b0);
      applyStimulus(32'hEE33EEEE, 2, 1, 1'b0);
      applyStimulus(32'h44EEEEEE, 3, 1, 1'b0);
      waitTxValid("pack_tx_timeout");
      checkOutput("pack_tx_data", tx_data, 32'h44332211);
      checkOutput("pack_tx_size", 32'(tx_size), 32'd4);
      checkOutput("pack_tx_offset", 32'(tx_offset), 32'd0);
      tx_ready = 1'b1;
      tx_err   = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      tx_err   = 1'b0;
      @(negedge clk);
      checkOutput("pack_tx_consumed", 32'(tx_valid), 32'd0);
      checkOutput("pack_cnt_tx_err", 32'(status_cnt_tx_err), 32'd1);
   endtask

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      checkOutput("reset_rx_ready", 32'(rx_ready), 32'd0);
      checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("reset_buf_lvl", 32'(buf_lvl), 32'd0);
      checkOutput("reset_tx_data", tx_data, 32'd0);
      checkOutput("reset_cnt_drop", 32'(status_cnt_drop), 32'd0);
      reset  = 1'b0;
      chk_en = 1'b1;
      @(posedge clk);
      #1;

      // Scenario 1: packing.
      runPackScenario();

      // Scenario 2: one 4-byte RX split into two back-to-back 2-byte TX words at offset 2.
      ctrl_size   = 3'd2;
      ctrl_offset = 2'd2;
      tx_ready    = 1'b1;
      applyStimulus(32'hDDCCBBAA, 0, 4, 1'b0);
      waitTxValid("split_tx_timeout");
      checkOutput("split_word0", tx_data, 32'hBBAA0000);
      checkOutput("split_size", 32'(tx_size), 32'd2);
      checkOutput("split_offset", 32'(tx_offset), 32'd2);
      @(negedge clk);
      checkOutput("split_word1_valid", 32'(tx_valid), 32'd1);
      checkOutput("split_word1", tx_data, 32'hDDCC0000);
      @(negedge clk);
      checkOutput("split_done", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;

      // Scenario 3: illegal RX (offset 2 + size 3 > 4).
      applyStimulus(32'h12345678, 2, 3, 1'b1);
      @(negedge clk);
      checkOutput("illegal_cnt_drop", 32'(status_cnt_drop), 32'd1);
      checkOutput("illegal_buf_lvl", 32'(buf_lvl), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("illegal_no_tx", 32'(tx_valid), 32'd0);

      // Scenario 4: full buffer backpressure, released by one TX handshake.
      ctrl_size   = 3'd1;
      ctrl_offset = 2'd0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(32'(8'h30 + i) << (8 * (i % 4)), i % 4, 1, 1'b0);
      end
      @(negedge clk);
      checkOutput("full_buf_lvl", 32'(buf_lvl), 32'd8);
      checkOutput("full_tx_word", tx_data, 32'h00000030);
      rx_valid  = 1'b1;
      rx_data   = 32'h00000039;
      rx_offset = 2'd0;
      rx_size   = 3'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("full_backpressure", 32'(rx_ready), 32'd0);
      end
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      seen = 1'b0;
      for (int i = 0; (i < 2) && !seen; i++) begin
         @(negedge clk);
         if (rx_ready) seen = 1'b1;
      end
      checkOutput("full_release_rx_ready", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; (i < 40) && !seen; i++) begin
         @(negedge clk);
         if (!tx_valid && (buf_lvl == 4'd0)) seen = 1'b1;
      end
      checkOutput("full_drain_buf_lvl", 32'(buf_lvl), 32'd0);
      tx_ready = 1'b0;

      // Scenario 5: flush with a stalled TX word.
      applyStimulus(32'h000000AA, 0, 1, 1'b0);
      applyStimulus(32'h0000BB00, 1, 1, 1'b0);
      applyStimulus(32'h00CC0000, 2, 1, 1'b0);
      applyStimulus(32'hDD000000, 3, 1, 1'b0);
      @(negedge clk);
      checkOutput("flush_pre_lvl", 32'(buf_lvl), 32'd3);
      ctrl_clr = 1'b1;
      @(posedge clk);
      #1;
      ctrl_clr = 1'b0;
      @(negedge clk);
      checkOutput("flush_buf_lvl", 32'(buf_lvl), 32'd0);
      checkOutput("flush_tx_valid", 32'(tx_valid), 32'd1);
      checkOutput("flush_tx_data", tx_data, 32'h000000AA);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      @(negedge clk);
      checkOutput("flush_tx_drained", 32'(tx_valid), 32'd0);

      // Scenario 6: asynchronous reset with a stalled TX word, then packing again.
      applyStimulus(32'h0000005A, 0, 1, 1'b0);
      waitTxValid("reset_stall_timeout");
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("async_rx_ready", 32'(rx_ready), 32'd0);
      checkOutput("async_buf_lvl", 32'(buf_lvl), 32'd0);
      checkOutput("async_cnt_drop", 32'(status_cnt_drop), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      runPackScenario();

      // Illegal ctrl config: RX keeps filling, nothing is emitted.
      ctrl_size   = 3'd3;
      ctrl_offset = 2'd2;
      applyStimulus(32'h87654321, 0, 4, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("badctrl_no_tx", 32'(tx_valid), 32'd0);
      checkOutput("badctrl_buf_lvl", 32'(buf_lvl), 32'd4);
      ctrl_clr = 1'b1;
      @(posedge clk);
      #1;
      ctrl_clr = 1'b0;

      // Drop counter saturation.
      for (int i = 0; i < 256; i++) begin
         if ((i % 2) == 0) applyStimulus(32'h0, 0, 0, 1'b1);
         else applyStimulus(32'hFFFFFFFF, 1, 4, 1'b1);
      end
      @(negedge clk);
      checkOutput("drop_saturated", 32'(status_cnt_drop), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
